// File: rtl/mux_tree_pipe_if.sv
// mux_tree_pipe_if: channel-select bus for mux_tree_pipe.
//   in_data   N*WIDTH flattened channels, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid  sample request this cycle
//   mode      0 = manual select (sel), 1 = auto-scan (internal counter)
//   sel       manual channel select
//   out_data  selected channel data
//   out_valid out_data/out_chan valid
//   out_chan  channel index that produced out_data
//   scan_wrap last channel of an auto-scan sweep, qualified by out_valid
// master = the sampling source, slave = the mux tree.
interface mux_tree_pipe_if #(
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 4
);
   localparam int N = 2**SEL_BITS;

   logic [N*WIDTH-1:0]  in_data;
   logic                in_valid;
   logic                mode;
   logic [SEL_BITS-1:0] sel;
   logic [WIDTH-1:0]    out_data;
   logic                out_valid;
   logic [SEL_BITS-1:0] out_chan;
   logic                scan_wrap;

   modport master (
      output in_data, in_valid, mode, sel,
      input  out_data, out_valid, out_chan, scan_wrap
   );

   modport slave (
      input  in_data, in_valid, mode, sel,
      output out_data, out_valid, out_chan, scan_wrap
   );
endinterface

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 channel mux built from registered 4:1 stages
// (2:1 on the last stage when SEL_BITS is odd), with valid pipeline, channel
// tag and an auto-scan counter.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_tree_pipe_if.slave (inputs in_data/in_valid/mode/sel,
//        outputs out_data/out_valid/out_chan/scan_wrap)
// Latency is ceil(SEL_BITS/2) cycles, one sample per cycle, no stalls.

// One tree level: NI inputs reduced by 2**B using tag bits [LO +: B].
// Valid shifts every cycle; data/tag/wrap load only on valid so the output
// holds the last real sample through bubbles.
module mux_tree_stage #(
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 4,
   parameter int NI       = 16,
   parameter int LO       = 0,
   parameter int B        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         vin,
   input  logic [NI-1:0][WIDTH-1:0]     din,
   input  logic [SEL_BITS-1:0]          tin,
   input  logic                         win,
   output logic                         vout,
   output logic [(NI>>B)-1:0][WIDTH-1:0] dout,
   output logic [SEL_BITS-1:0]          tout,
   output logic                         wout
);
   localparam int NO = NI >> B;
   localparam int F  = 1 << B;
   localparam int IW = $clog2(NI);

   logic [NO-1:0][WIDTH-1:0] m;
   logic [IW-1:0]            idx;

   always_comb begin
      m   = '0;
      idx = '0;
      for (int j = 0; j < NO; j++) begin
         idx  = IW'(j * F + int'(tin[LO +: B]));
         m[j] = din[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vout <= 1'b0;
         dout <= '0;
         tout <= '0;
         wout <= 1'b0;
      end else begin
         vout <= vin;
         if (vin) begin
            dout <= m;
            tout <= tin;
            wout <= win;
         end
      end
   end
endmodule

module mux_tree_pipe #(
   parameter int WIDTH    = 8,
   parameter int SEL_BITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   mux_tree_pipe_if.slave  bus
);
   localparam int N = 2**SEL_BITS;
   localparam int L = (SEL_BITS + 1) / 2;

   logic [SEL_BITS-1:0]          scan_cnt;
   logic [SEL_BITS-1:0]          eff_sel;
   logic [L:0]                   vld_pipe;
   logic [L:0]                   wrap_pipe;
   logic [L:0][SEL_BITS-1:0]     tag_pipe;
   logic [N-1:0][WIDTH-1:0]      chans;

   assign chans   = bus.in_data;
   assign eff_sel = bus.mode ? scan_cnt : bus.sel;

   // Counter survives mode changes so a return to scan resumes where it left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         scan_cnt <= '0;
      else if (bus.mode && bus.in_valid)
         scan_cnt <= scan_cnt + SEL_BITS'(1);
   end

   // The full eff_sel rides along as the tag; each stage consumes its own
   // two (or one) bits of it. The wrap flag only latches on valid samples.
   assign vld_pipe[0]  = bus.in_valid;
   assign tag_pipe[0]  = eff_sel;
   assign wrap_pipe[0] = bus.mode & (&scan_cnt) & bus.in_valid;

   for (genvar k = 0; k < L; k++) begin : g_stg
      localparam int LO = 2 * k;
      localparam int B  = (SEL_BITS - LO >= 2) ? 2 : 1;
      localparam int NI = N >> LO;

      logic [NI-1:0][WIDTH-1:0]       din;
      logic [(NI>>B)-1:0][WIDTH-1:0]  dq;

      if (k == 0) begin : g_head
         assign din = chans;
      end else begin : g_body
         assign din = g_stg[k-1].dq;
      end

      mux_tree_stage #(
         .WIDTH(WIDTH), .SEL_BITS(SEL_BITS), .NI(NI), .LO(LO), .B(B)
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .vin  (vld_pipe[k]),
         .din  (din),
         .tin  (tag_pipe[k]),
         .win  (wrap_pipe[k]),
         .vout (vld_pipe[k+1]),
         .dout (dq),
         .tout (tag_pipe[k+1]),
         .wout (wrap_pipe[k+1])
      );
   end

   assign bus.out_data  = g_stg[L-1].dq[0];
   assign bus.out_valid = vld_pipe[L];
   assign bus.out_chan  = tag_pipe[L];
   assign bus.scan_wrap = wrap_pipe[L] & vld_pipe[L];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: drives one shared stimulus stream into three mux trees
// (SEL_BITS = 4, 3, 1). Each has a reference model that pushes expected
// samples on the sampling edge and a monitor that pops on out_valid.
module tb_mux_tree_pipe;
   logic       clk;
   logic       rst;
   logic       valid_c;
   logic       mode_c;
   logic [3:0] sel_c;
   logic [7:0] chdata [16];
   event       done_ev;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      int         ch;
      bit         w;
      int         due;
   } exp_t;

   function automatic void chk(bit ok, string name, int act, int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
      end
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int SB = (g == 0) ? 4 : (g == 1) ? 3 : 1;
      localparam int N  = 1 << SB;
      localparam int L  = (SB == 1) ? 1 : 2;

      mux_tree_pipe_if #(.WIDTH(8), .SEL_BITS(SB)) bus ();
      mux_tree_pipe #(.WIDTH(8), .SEL_BITS(SB)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      for (genvar i = 0; i < N; i++) begin : g_ch
         assign bus.in_data[i*8 +: 8] = chdata[i];
      end
      assign bus.in_valid = valid_c;
      assign bus.mode     = mode_c;
      assign bus.sel      = sel_c[SB-1:0];

      exp_t       q[$];
      int         mcnt   = 0;
      int         cyc    = 0;
      logic [7:0] last_d = 8'h00;
      int         last_c = 0;

      // Reference model: channel = scan count or sel, advance count on scan.
      always @(posedge clk or posedge rst) begin
         int ch;
         if (rst) begin
            q.delete();
            mcnt   = 0;
            last_d = 8'h00;
            last_c = 0;
         end else begin
            if (valid_c === 1'b1) begin
               ch = mode_c ? mcnt : (int'(sel_c) % N);
               q.push_back('{d: chdata[ch], ch: ch,
                             w: (mode_c && mcnt == N - 1), due: cyc + L});
               if (mode_c) mcnt = (mcnt + 1) % N;
            end
            cyc++;
         end
      end

      always @(negedge clk) begin
         exp_t e;
         if (!rst) begin
            if (bus.out_valid) begin
               chk(q.size() != 0, $sformatf("sb%0d spurious_valid", SB), 1, 0);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk(bus.out_data == e.d, $sformatf("sb%0d data", SB),
                      int'(bus.out_data), int'(e.d));
                  chk(int'(bus.out_chan) == e.ch, $sformatf("sb%0d chan", SB),
                      int'(bus.out_chan), e.ch);
                  chk(bus.scan_wrap == e.w, $sformatf("sb%0d wrap", SB),
                      int'(bus.scan_wrap), int'(e.w));
                  chk(cyc == e.due, $sformatf("sb%0d latency", SB), cyc, e.due);
                  last_d = e.d;
                  last_c = e.ch;
               end
            end else begin
               chk(bus.out_data == last_d, $sformatf("sb%0d hold_data", SB),
                   int'(bus.out_data), int'(last_d));
               chk(int'(bus.out_chan) == last_c && !bus.scan_wrap,
                   $sformatf("sb%0d hold_chan", SB),
                   int'(bus.out_chan) + 256 * int'(bus.scan_wrap), last_c);
            end
         end
      end

      always @(posedge rst) begin
         #1;
         chk(!bus.out_valid && !bus.scan_wrap, $sformatf("sb%0d reset_valid", SB),
             int'(bus.out_valid) * 2 + int'(bus.scan_wrap), 0);
         chk(bus.out_data == 8'h00 && bus.out_chan == '0,
             $sformatf("sb%0d reset_data", SB),
             int'(bus.out_data) + 256 * int'(bus.out_chan), 0);
      end

      always @(done_ev) begin
         chk(q.size() == 0, $sformatf("sb%0d missing_outputs", SB), q.size(), 0);
      end
   end

   task automatic drive(input bit v, input bit m, input int s);
      @(posedge clk);
      #1;
      valid_c = v;
      mode_c  = m;
      sel_c   = s[3:0];
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 0);
   endtask

   initial begin
      rst     = 1'b0;
      valid_c = 1'b0;
      mode_c  = 1'b0;
      sel_c   = 4'h0;
      for (int i = 0; i < 16; i++) chdata[i] = 8'hA0 + 8'(i);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // single manual pulse, then hold
      drive(1'b1, 1'b0, 9);
      idle(4);

      // manual back-to-back
      drive(1'b1, 1'b0, 0);
      drive(1'b1, 1'b0, 5);
      drive(1'b1, 1'b0, 15);
      drive(1'b1, 1'b0, 3);
      idle(3);

      // auto-scan sweep past the wrap
      repeat (18) drive(1'b1, 1'b1, 0);
      idle(3);

      // scan with bubbles up to count 6, manual detour, resume scan
      repeat (4) begin
         drive(1'b1, 1'b1, 0);
         drive(1'b0, 1'b1, 0);
      end
      repeat (3) drive(1'b1, 1'b0, 2);
      drive(1'b1, 1'b1, 0);
      drive(1'b1, 1'b1, 0);
      idle(3);

      // asynchronous reset with two samples in flight
      drive(1'b1, 1'b0, 4);
      drive(1'b1, 1'b0, 11);
      @(posedge clk);
      #1 valid_c = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(3);
      drive(1'b1, 1'b0, 13);
      idle(4);

      // exhaustive manual sweep
      for (int s = 0; s < 16; s++) drive(1'b1, 1'b0, s);
      idle(3);

      // randomized traffic with occasional new channel data
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)));
         if (n % 50 == 0)
            for (int i = 0; i < 16; i++) chdata[i] = 8'($urandom);
      end
      idle(5);

      -> done_ev;
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
